nn_layer_sequencer: RTL

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

---
 rtl/nn_seq_pkg.sv | 25 ++
 rtl/nn_seq_addr_gen.sv | 57 +++++
 rtl/nn_layer_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/nn_seq_pkg.sv
`default_nettype none
// ============================================================================
// nn_seq_pkg : shared state encoding and default widths for the layer sequencer
// Rev 1.0
// ============================================================================
package nn_seq_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int CNT_W_DEFAULT  = 8;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_FETCH = 4'd2,
        S_MAC   = 4'd3,
        S_BIAS  = 4'd4,
        S_ADDB  = 4'd5,
        S_ACT   = 4'd6,
        S_WRITE = 4'd7,
        S_DONE  = 4'd8,
        S_X     = 4'bxxxx
    } nn_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_seq_addr_gen.sv
`default_nettype none
// ============================================================================
// nn_seq_addr_gen : input index i, neuron index j and running weight pointer
// Rev 1.0
// ============================================================================
module nn_seq_addr_gen
    import nn_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_all,
    input  logic              i_clr_i,
    input  logic              i_inc_iw,
    input  logic              i_inc_j,
    output logic [CNT_W-1:0]  o_i,
    output logic [CNT_W-1:0]  o_j,
    output logic [ADDR_W-1:0] o_wptr
);

    logic [CNT_W-1:0]  r_i;
    logic [CNT_W-1:0]  r_j;
    logic [ADDR_W-1:0] r_wptr;

    // wptr only clears at layer start: weights are row-major across neurons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i    <= '0;
            r_j    <= '0;
            r_wptr <= '0;
        end else if (i_clr_all) begin
            r_i    <= '0;
            r_j    <= '0;
            r_wptr <= '0;
        end else begin
            if (i_clr_i) begin
                r_i <= '0;
            end else if (i_inc_iw) begin
                r_i <= r_i + CNT_W'(1);
            end
            if (i_inc_iw) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (i_inc_j) begin
                r_j <= r_j + CNT_W'(1);
            end
        end
    end

    assign o_i    = r_i;
    assign o_j    = r_j;
    assign o_wptr = r_wptr;

endmodule
`default_nettype wire

// File: rtl/nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// nn_layer_sequencer : FSM sequencing fetch/MAC/bias/activate/write of a layer
// Rev 1.0
// ============================================================================
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_in,
    input  logic [CNT_W-1:0]  n_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              bias_en,
    output logic              act_en,
    output logic              out_wr_en
);

    nn_state_t        r_state;
    logic [CNT_W-1:0] r_n_in;
    logic [CNT_W-1:0] r_n_out;
    logic             r_busy, r_done, r_err, r_rd_en;
    logic             r_acc_clr, r_acc_en, r_bias_en, r_act_en, r_out_wr_en;

    logic [CNT_W-1:0]  w_i;
    logic [CNT_W-1:0]  w_j;
    logic [ADDR_W-1:0] w_wptr;
    logic              w_abort, w_last_i, w_last_j, w_zero;

    assign w_abort  = abort && (r_state != S_IDLE);
    assign w_last_i = (w_i == r_n_in - CNT_W'(1));
    assign w_last_j = (w_j == r_n_out - CNT_W'(1));
    assign w_zero   = (r_n_in == '0) || (r_n_out == '0);

    nn_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr_all (r_state == S_IDLE && start),
        .i_clr_i   (r_state == S_CLR && !w_abort),
        .i_inc_iw  (r_state == S_MAC && !w_abort),
        .i_inc_j   (r_state == S_WRITE && !w_last_j && !w_abort),
        .o_i       (w_i),
        .o_j       (w_j),
        .o_wptr    (w_wptr)
    );

    // Strobes are registered alongside the state they belong to (Moore)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n_in      <= '0;
            r_n_out     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_bias_en   <= 1'b0;
            r_act_en    <= 1'b0;
            r_out_wr_en <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_acc_en    <= 1'b0;
            r_bias_en   <= 1'b0;
            r_act_en    <= 1'b0;
            r_out_wr_en <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_n_in    <= n_in;
                            r_n_out   <= n_out;
                            r_state   <= S_CLR;
                            r_busy    <= 1'b1;
                            // a zero-count layer passes through CLR silently
                            r_acc_clr <= (n_in != '0) && (n_out != '0);
                        end
                    end
                    S_CLR: begin
                        if (w_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_rd_en <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_state  <= S_MAC;
                        r_acc_en <= 1'b1;
                    end
                    S_MAC: begin
                        r_state <= w_last_i ? S_BIAS : S_FETCH;
                        r_rd_en <= 1'b1;
                    end
                    S_BIAS: begin
                        r_state   <= S_ADDB;
                        r_bias_en <= 1'b1;
                    end
                    S_ADDB: begin
                        r_state  <= S_ACT;
                        r_act_en <= 1'b1;
                    end
                    S_ACT: begin
                        r_state     <= S_WRITE;
                        r_out_wr_en <= 1'b1;
                    end
                    S_WRITE: begin
                        if (w_last_j) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_CLR;
                            r_acc_clr <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_en     = r_rd_en;
    assign acc_clr   = r_acc_clr;
    assign acc_en    = r_acc_en;
    assign bias_en   = r_bias_en;
    assign act_en    = r_act_en;
    assign out_wr_en = r_out_wr_en;
    assign in_addr   = ADDR_W'(w_i);
    assign w_addr    = w_wptr;
    assign b_addr    = ADDR_W'(w_j);
    assign out_addr  = ADDR_W'(w_j);

endmodule
`default_nettype wire
